// File: rtl/ktms_pkg.sv
// ktms_pkg: shared constants and helpers for the ktms MMIO write path.
// Holds clog2 and the context-id slice layout used by decoders and arbiters.
package ktms_pkg;

    // Parity bit position inside each packed context-id slice.
    localparam int KTMS_CTXT_PAR_BIT = 0;

    // Bits needed to encode 0..n-1 (minimum 1).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/capi_parity_gen.sv
// capi_parity_gen: odd parity over width equal groups of a dwidth-bit word.
// Ports: i_d data in, o_d one parity bit per group (combinational).
module capi_parity_gen #(
    parameter int dwidth = 9,
    parameter int width  = 1
) (
    input  logic [dwidth-1:0] i_d,
    output logic [width-1:0]  o_d
);

    localparam int bw = dwidth / width;

    for (genvar g = 0; g < width; g++) begin : g_par
        // Odd parity: data plus parity bit holds an odd count of ones.
        assign o_d[g] = ~^i_d[g*bw +: bw];
    end

endmodule

// File: rtl/ktms_rr_pick.sv
// ktms_rr_pick: combinational round-robin picker.
// Ports: req request vector, ptr scan start; gnt one-hot, idx encoded, any.
module ktms_rr_pick #(
    parameter int ways      = 4,
    parameter int src_width = 2
) (
    input  logic [ways-1:0]      req,
    input  logic [src_width-1:0] ptr,
    output logic [ways-1:0]      gnt,
    output logic [src_width-1:0] idx,
    output logic                 any
);

    always_comb begin
        int k;
        gnt = '0;
        idx = '0;
        k   = 0;
        any = |req;
        // Scan from the far end back toward ptr so the closest hit wins.
        for (int off = ways - 1; off >= 0; off--) begin
            k = int'(ptr) + off;
            if (k >= ways) k = k - ways;
            if (req[k]) begin
                gnt    = '0;
                gnt[k] = 1'b1;
                idx    = src_width'(k);
            end
        end
    end

endmodule

// File: rtl/ktms_mmwr_ctxt_arb.sv
// ktms_mmwr_ctxt_arb: round-robin merge of decoder write streams into one
// registered write port; drops writes with bad ctxt parity (o_perror pulse).
// Ports: i_v/i_r/i_ctxt/i_addr/i_d requesters; o_v/o_r/o_ctxt/o_addr/o_src/o_d
// merged output; o_perror/o_perror_src dropped-write report.
module ktms_mmwr_ctxt_arb
    import ktms_pkg::*;
#(
    parameter int ways          = 4,
    parameter int ctxtid_width  = 10,
    parameter int lcladdr_width = 1,
    parameter int src_width     = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ways-1:0]                 i_v,
    output logic [ways-1:0]                 i_r,
    input  logic [ways*ctxtid_width-1:0]    i_ctxt,
    input  logic [ways*lcladdr_width-1:0]   i_addr,
    input  logic [ways*64-1:0]              i_d,
    output logic                            o_v,
    input  logic                            o_r,
    output logic [ctxtid_width-1:0]         o_ctxt,
    output logic [lcladdr_width-1:0]        o_addr,
    output logic [src_width-1:0]            o_src,
    output logic [63:0]                     o_d,
    output logic                            o_perror,
    output logic [src_width-1:0]            o_perror_src
);

    localparam int pw = clog2(ways);

    logic [pw-1:0]            ptr_q, ptr_d;
    logic                     v_q, v_d;
    logic [ctxtid_width-1:0]  ctxt_q, ctxt_d;
    logic [lcladdr_width-1:0] addr_q, addr_d;
    logic [src_width-1:0]     src_q, src_d;
    logic [63:0]              d_q, d_d;
    logic                     perr_q, perr_d;
    logic [src_width-1:0]     perr_src_q, perr_src_d;

    logic [ways-1:0]          gnt;
    logic [src_width-1:0]     win;
    logic                     any;
    logic [ctxtid_width-1:0]  w_ctxt;
    logic [lcladdr_width-1:0] w_addr;
    logic [63:0]              w_d;
    logic [0:0]               w_par;
    logic                     load_ok, accept, par_ok, load;

    ktms_rr_pick #(
        .ways      (ways),
        .src_width (src_width)
    ) u_pick (
        .req (i_v),
        .ptr (src_width'(ptr_q)),
        .gnt (gnt),
        .idx (win),
        .any (any)
    );

    assign w_ctxt = i_ctxt[int'(win)*ctxtid_width +: ctxtid_width];
    assign w_addr = i_addr[int'(win)*lcladdr_width +: lcladdr_width];
    assign w_d    = i_d[int'(win)*64 +: 64];

    capi_parity_gen #(
        .dwidth (ctxtid_width - 1),
        .width  (1)
    ) u_par (
        .i_d (w_ctxt[ctxtid_width-1:1]),
        .o_d (w_par)
    );

    assign load_ok = ~v_q | o_r;
    assign accept  = any & load_ok & ~reset;
    assign par_ok  = (w_par[0] == w_ctxt[KTMS_CTXT_PAR_BIT]);
    assign load    = accept & par_ok;
    assign i_r     = accept ? gnt : '0;

    always_comb begin
        int nxt;
        ptr_d      = ptr_q;
        ctxt_d     = ctxt_q;
        addr_d     = addr_q;
        src_d      = src_q;
        d_d        = d_q;
        perr_src_d = perr_src_q;
        nxt        = int'(win) + 1;
        if (nxt >= ways) nxt = 0;
        // Stage stays full only if it held data and nothing drained it.
        v_d    = load | (v_q & ~o_r);
        perr_d = accept & ~par_ok;
        if (accept) ptr_d = pw'(nxt);
        if (load) begin
            ctxt_d = w_ctxt;
            addr_d = w_addr;
            src_d  = win;
            d_d    = w_d;
        end
        if (perr_d) perr_src_d = win;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q      <= '0;
            v_q        <= 1'b0;
            ctxt_q     <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            d_q        <= '0;
            perr_q     <= 1'b0;
            perr_src_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            v_q        <= v_d;
            ctxt_q     <= ctxt_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            d_q        <= d_d;
            perr_q     <= perr_d;
            perr_src_q <= perr_src_d;
        end
    end

    assign o_v          = v_q;
    assign o_ctxt       = ctxt_q;
    assign o_addr       = addr_q;
    assign o_src        = src_q;
    assign o_d          = d_q;
    assign o_perror     = perr_q;
    assign o_perror_src = perr_src_q;

endmodule

// File: tb/tb_ktms_mmwr_ctxt_arb.sv
// tb_ktms_mmwr_ctxt_arb: directed scenarios for the ctxt write arbiter.
// Ways=4, ctxt 10 bits (odd parity in lsb), 1-bit address, 64-bit data.
module tb_ktms_mmwr_ctxt_arb;

    logic         clk;
    logic         reset;
    logic [3:0]   i_v;
    logic [3:0]   i_r;
    logic [39:0]  i_ctxt;
    logic [3:0]   i_addr;
    logic [255:0] i_d;
    logic         o_v;
    logic         o_r;
    logic [9:0]   o_ctxt;
    logic [0:0]   o_addr;
    logic [1:0]   o_src;
    logic [63:0]  o_d;
    logic         o_perror;
    logic [1:0]   o_perror_src;

    int errors = 0;
    int checks = 0;

    ktms_mmwr_ctxt_arb #(
        .ways          (4),
        .ctxtid_width  (10),
        .lcladdr_width (1),
        .src_width     (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_v          (i_v),
        .i_r          (i_r),
        .i_ctxt       (i_ctxt),
        .i_addr       (i_addr),
        .i_d          (i_d),
        .o_v          (o_v),
        .o_r          (o_r),
        .o_ctxt       (o_ctxt),
        .o_addr       (o_addr),
        .o_src        (o_src),
        .o_d          (o_d),
        .o_perror     (o_perror),
        .o_perror_src (o_perror_src)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [9:0] good_ctxt(input logic [8:0] id);
        return {id, ~^id};
    endfunction

    function automatic logic [63:0] dval(input int k);
        return 64'hC0DE_0000_0000_0000 | 64'(k);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [9:0] c,
                           input logic a, input logic [63:0] d);
        i_ctxt[k*10 +: 10] = c;
        i_addr[k]          = a;
        i_d[k*64 +: 64]    = d;
    endtask

    task automatic load_defaults();
        for (int k = 0; k < 4; k++)
            set_req(k, good_ctxt(9'(8'h30 + k)), k[0], dval(k));
    endtask

    task automatic do_reset();
        reset = 1;
        i_v   = '0;
        o_r   = 1'b0;
        step();
        step();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        i_v   = 4'b1111;
        o_r   = 1'b1;
        load_defaults();
        #3;
        checks++;
        if (i_r !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ir got=%b want=0000", i_r);
        end
        step();
        checks++;
        if ({o_v, o_ctxt, o_addr, o_src, o_d, o_perror, o_perror_src} !== '0) begin
            errors++;
            $display("FAIL reset_outs got v=%b c=%h s=%0d d=%h pe=%b",
                     o_v, o_ctxt, o_src, o_d, o_perror);
        end
        i_v = '0;
        reset = 0;
        #1;
    endtask

    task automatic test_single();
        do_reset();
        o_r = 1;
        set_req(0, 10'h1A5, 1'b1, 64'hDEADBEEF_00000001);
        i_v = 4'b0001;
        #1;
        checks++;
        if (i_r !== 4'b0001) begin
            errors++;
            $display("FAIL single_ir got=%b want=0001", i_r);
        end
        step();
        i_v = '0;
        checks++;
        if (o_v !== 1'b1 || o_src !== 2'd0 || o_ctxt !== 10'h1A5 ||
            o_addr !== 1'b1 || o_d !== 64'hDEADBEEF_00000001) begin
            errors++;
            $display("FAIL single_out got v=%b s=%0d c=%h a=%b d=%h want 1 0 1a5 1 deadbeef00000001",
                     o_v, o_src, o_ctxt, o_addr, o_d);
        end
        step();
        checks++;
        if (o_v !== 1'b0) begin
            errors++;
            $display("FAIL single_drain got o_v=%b want=0", o_v);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        load_defaults();
        o_r = 1;
        i_v = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i_r !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL fair_ir[%0d] got=%b want=%b", i, i_r, 4'(1 << (i % 4)));
            end
            step();
            checks++;
            if (o_v !== 1'b1 || o_src !== 2'(i % 4) || o_d !== dval(i % 4)) begin
                errors++;
                $display("FAIL fair_out[%0d] got v=%b s=%0d want 1 %0d", i, o_v, o_src, i % 4);
            end
        end
        i_v = '0;
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        load_defaults();
        o_r = 0;
        i_v = 4'b0001;
        step();
        i_v = 4'b1111;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i_r !== 4'b0000 || o_v !== 1'b1 || o_src !== 2'd0 ||
                o_d !== dval(0) || o_ctxt !== good_ctxt(9'h30)) begin
                errors++;
                $display("FAIL bp_hold[%0d] got ir=%b v=%b s=%0d d=%h", i, i_r, o_v, o_src, o_d);
            end
            step();
        end
        o_r = 1;
        #1;
        checks++;
        if (i_r !== 4'b0010) begin
            errors++;
            $display("FAIL bp_release_ir got=%b want=0010", i_r);
        end
        step();
        i_v = '0;
        checks++;
        if (o_v !== 1'b1 || o_src !== 2'd1 || o_d !== dval(1)) begin
            errors++;
            $display("FAIL bp_release_out got v=%b s=%0d want 1 1", o_v, o_src);
        end
        step();
    endtask

    task automatic test_parity();
        do_reset();
        load_defaults();
        o_r = 1;
        set_req(2, good_ctxt(9'h0AB) ^ 10'h001, 1'b0, dval(2));
        i_v = 4'b0100;
        #1;
        checks++;
        if (i_r !== 4'b0100) begin
            errors++;
            $display("FAIL perr_ir got=%b want=0100", i_r);
        end
        step();
        i_v = 4'b1001;
        checks++;
        if (o_v !== 1'b0 || o_perror !== 1'b1 || o_perror_src !== 2'd2) begin
            errors++;
            $display("FAIL perr_pulse got v=%b pe=%b src=%0d want 0 1 2", o_v, o_perror, o_perror_src);
        end
        #1;
        checks++;
        if (i_r !== 4'b1000) begin
            errors++;
            $display("FAIL perr_ptr3 got=%b want=1000", i_r);
        end
        step();
        i_v = '0;
        checks++;
        if (o_perror !== 1'b0 || o_v !== 1'b1 || o_src !== 2'd3 ||
            o_ctxt !== good_ctxt(9'h33)) begin
            errors++;
            $display("FAIL perr_next got pe=%b v=%b s=%0d c=%h", o_perror, o_v, o_src, o_ctxt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        load_defaults();
        o_r = 1;
        set_req(1, good_ctxt(9'h111) ^ 10'h001, 1'b1, dval(1));
        set_req(2, good_ctxt(9'h022) ^ 10'h001, 1'b0, dval(2));
        i_v = 4'b0110;
        step();
        checks++;
        if (o_perror !== 1'b1 || o_perror_src !== 2'd1 || o_v !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got pe=%b src=%0d v=%b want 1 1 0", o_perror, o_perror_src, o_v);
        end
        step();
        i_v = '0;
        checks++;
        if (o_perror !== 1'b1 || o_perror_src !== 2'd2 || o_v !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got pe=%b src=%0d v=%b want 1 2 0", o_perror, o_perror_src, o_v);
        end
        step();
        checks++;
        if (o_perror !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got pe=%b want=0", o_perror);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        load_defaults();
        o_r = 0;
        i_v = 4'b0001;
        step();
        i_v = 4'b1111;
        #1;
        reset = 1;
        #1;
        checks++;
        if (o_v !== 1'b0 || o_d !== '0 || o_src !== '0 || o_ctxt !== '0 ||
            o_addr !== '0 || i_r !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async got v=%b d=%h s=%0d c=%h ir=%b", o_v, o_d, o_src, o_ctxt, i_r);
        end
        #1;
        reset = 0;
        o_r = 1;
        i_v = 4'b1000;
        #1;
        checks++;
        if (i_r !== 4'b1000) begin
            errors++;
            $display("FAIL rst_after_ir got=%b want=1000", i_r);
        end
        step();
        i_v = '0;
        checks++;
        if (o_v !== 1'b1 || o_src !== 2'd3) begin
            errors++;
            $display("FAIL rst_after_out got v=%b s=%0d want 1 3", o_v, o_src);
        end
        step();
    endtask

    task automatic test_sparse();
        do_reset();
        load_defaults();
        o_r = 1;
        i_v = 4'b0100;
        #1;
        checks++;
        if (i_r !== 4'b0100) begin
            errors++;
            $display("FAIL sparse_ir0 got=%b want=0100", i_r);
        end
        step();
        i_v = 4'b0000;
        #1;
        checks++;
        if (i_r !== 4'b0000 || o_v !== 1'b1 || o_src !== 2'd2) begin
            errors++;
            $display("FAIL sparse_idle_ir got ir=%b v=%b s=%0d", i_r, o_v, o_src);
        end
        step();
        checks++;
        if (o_v !== 1'b0) begin
            errors++;
            $display("FAIL sparse_idle_ov got=%b want=0", o_v);
        end
        i_v = 4'b0001;
        #1;
        checks++;
        if (i_r !== 4'b0001) begin
            errors++;
            $display("FAIL sparse_ir1 got=%b want=0001", i_r);
        end
        step();
        i_v = 4'b0101;
        #1;
        checks++;
        if (i_r !== 4'b0100 || o_src !== 2'd0 || o_v !== 1'b1) begin
            errors++;
            $display("FAIL sparse_ptr1 got ir=%b s=%0d v=%b want 0100 0 1", i_r, o_src, o_v);
        end
        step();
        i_v = '0;
        step();
    endtask

    initial begin
        reset  = 1;
        i_v    = '0;
        o_r    = 0;
        i_ctxt = '0;
        i_addr = '0;
        i_d    = '0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_parity();
        test_back_to_back();
        test_reset_mid_stall();
        test_sparse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ktms_mmwr_ctxt_arb.md
# ktms_mmwr_ctxt_arb

Round-robin arbiter that merges the decoded write streams of several multi-context MMIO write decoders into the single write port of the per-context register file. It sits between the decoders (each producing valid/ready, context id with parity, local address, 64-bit data) and the context register RAM. It checks context-id parity on the granted request and drops corrupted writes with an error pulse. The output is registered and stalls under backpressure.

## Interface
Parameters:
- ways, 4, number of requesting decoders (2..8)
- ctxtid_width, 10, context id width including trailing parity bit
- lcladdr_width, 1, local register address width per requester
- src_width, 2, width of source index; must be ≥ ceil(log2(ways))

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_v  input  ways  request valid, bit k = requester k
- i_r  output  ways  request accepted, bit k = requester k
- i_ctxt  input  ways*ctxtid_width  context ids; requester k at slice k; parity in the lsb of each slice
- i_addr  input  ways*lcladdr_width  local addresses, same packing
- i_d  input  ways*64  write data, same packing
- o_v  output  1  merged write valid
- o_r  input  1  register file ready
- o_ctxt  output  ctxtid_width  forwarded context id, parity preserved
- o_addr  output  lcladdr_width  forwarded local address
- o_src  output  src_width  index of the requester that produced o_*
- o_d  output  64  forwarded data
- o_perror  output  1  one-cycle pulse: parity error, write dropped
- o_perror_src  output  src_width  requester index of the dropped write

## Operation
- Output stage: one register set {v, ctxt, addr, src, d}. It can load when empty, or when draining in the same cycle (o_v & o_r).
- Arbitration: combinational. The scan starts at pointer ptr (0..ways-1) and goes upward with wrap. The first k with i_v[k] wins.
  - i_r[k] = grant[k] & load_ok.
  - At most one i_r bit is high per cycle.
  - i_r is never high for a requester whose i_v is low.
- Pointer: after each accept from requester k, ptr ← (k+1) mod ways. The pointer is unchanged in cycles with no accept.
- Parity: the winner's ctxt[0:ctxtid_width-2] goes through the same generator the decoders use. The result is compared to ctxt lsb.
  - Match: the request loads the output stage.
  - Mismatch: the request is still accepted (i_r high) and the pointer still advances. The output stage is not loaded, so o_v falls if it was draining. Next cycle o_perror=1 and o_perror_src=k.
- Payload is forwarded unmodified, including the parity bit.
- No reordering within one requester. Between requesters, order follows the grant sequence.

## Timing
- Reset values: o_v=0, o_ctxt=0, o_addr=0, o_src=0, o_d=0, o_perror=0, o_perror_src=0, ptr=0. i_r=0 while reset is asserted.
- Latency: an accept in cycle N gives o_v=1 with payload in cycle N+1.
- Throughput: one write per cycle while o_r=1.
- Backpressure:
  - o_v=1 & o_r=0: the output stage holds all payload stable and i_r=0.
  - A requester holding i_v waits; fairness is retained because ptr did not move.
- Simultaneous drain and accept: allowed in the same cycle, with no bubble.
- Parity error while the stage is full and o_r=0: no accept happens, so there is no error pulse until the request is accepted.
- Back-to-back parity errors: o_perror stays high on consecutive cycles, with o_perror_src updated each cycle.
- Reset mid-operation: the held output write is lost, o_v drops immediately (asynchronous), and ptr returns to 0.

## Structure
- Shared package (ktms_pkg) holds:
  - function clog2
  - the ctxt-slice packing constant used by decoders and this block
- Sub-module: reuse capi_parity_gen (dwidth=ctxtid_width-1, width=1), one instance on the muxed winner's context.
- Optional local sub-module: ktms_rr_pick.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational, and reusable by other ktms arbiters.

## Test plan
- Single request: ways=4, i_v=0001, ctxt=0x1A5 with good parity, addr=1, d=0xDEADBEEF_00000001, o_r=1 → i_r=0001 in cycle 0; cycle 1 o_v=1, o_src=0, payload identical.
- Fairness: all four i_v held high for 8 cycles, o_r=1 → grant order 0,1,2,3,0,1,2,3, one per cycle, o_v continuous.
- Backpressure: stage full, o_r=0 for 5 cycles with i_v=1111 → i_r=0000 and payload stable throughout. When o_r rises, the drain and the next accept (requester ptr) happen in the same cycle.
- Parity error: requester 2 sends ctxt with the lsb flipped → i_r[2]=1, o_v=0 next cycle, o_perror=1 for exactly one cycle with o_perror_src=2, ptr=3. A following good request from 3 is forwarded normally.
- Reset mid-stall: o_v=1, o_r=0, reset asserted asynchronously → o_v=0 and all outputs 0 before the next clk edge. After release, i_v=1000 → grant 3, o_src=3.
- Sparse requests: i_v toggles 0100/0000/0001 → ptr moves 0→3→3→1. No spurious i_r, and o_v=0 on idle cycles.
